// File: rtl/uart_log_arbiter.sv
// Round-robin arbiter that shares one APB UART TX register among NUM_REQ byte streams,
// holding a per-line lock so text lines from different requesters never interleave.
module uart_log_arbiter #(
    parameter int                        NUM_REQ        = 4,
    parameter int                        APB_ADDR_WIDTH = 32,
    parameter int                        APB_DATA_WIDTH = 32,
    parameter logic [APB_ADDR_WIDTH-1:0] UART_ADDR      = 32'h1000_0000,
    parameter int                        LOCK_TIMEOUT   = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*8-1:0]        req_data_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic                        psel_o,
    output logic                        penable_o,
    output logic                        pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]   paddr_o,
    output logic [APB_DATA_WIDTH-1:0]   pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0]   prdata_i,
    input  logic                        pready_i,
    input  logic                        pslverr_i,
    output logic                        busy_o,
    output logic                        lock_valid_o,
    output logic [$clog2(NUM_REQ)-1:0]  lock_owner_o,
    output logic                        err_o
);

    localparam int               IDX_W     = $clog2(NUM_REQ);
    localparam int               CNT_W     = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam bit               LOCK_EN   = (LOCK_TIMEOUT > 0);
    localparam logic [31:0]      NUM_REQ_U = NUM_REQ;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
    localparam logic [7:0]       NEWLINE   = 8'h0A;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t             state_reg, state_next;
    logic [7:0]         byte_reg, byte_next;
    logic               lock_valid_reg, lock_valid_next;
    logic [IDX_W-1:0]   lock_owner_reg, lock_owner_next;
    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               err_reg, err_next;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] rot;
    logic [7:0]         req_byte [NUM_REQ];
    logic               found;
    logic [IDX_W-1:0]   offset;
    logic [IDX_W-1:0]   winner;
    logic               unused_prdata;

    assign unused_prdata = ^prdata_i;

    function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = {{(32-IDX_W){1'b0}}, a} + b;
        return IDX_W'(s % NUM_REQ_U);
    endfunction

    // rot[k] is the eligibility of the requester k places above rr_ptr (with wrap)
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign req_byte[gi] = req_data_i[8*gi +: 8];
        assign eligible[gi] = req_valid_i[gi] &&
                              (!(LOCK_EN && lock_valid_reg) || (lock_owner_reg == IDX_W'(gi)));
        assign rot[gi]      = eligible[idx_add(rr_ptr_reg, 32'(gi))];
    end

    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found  = 1'b1;
                offset = IDX_W'(k);
            end
        end
    end

    assign winner = idx_add(rr_ptr_reg, {{(32-IDX_W){1'b0}}, offset});

    always_comb begin
        state_next      = state_reg;
        byte_next       = byte_reg;
        lock_valid_next = lock_valid_reg;
        lock_owner_next = lock_owner_reg;
        rr_ptr_next     = rr_ptr_reg;
        cnt_next        = cnt_reg;
        err_next        = err_reg;
        req_ready_o     = '0;
        case (state_reg)
            IDLE: begin
                // An accept always beats a timeout release in the same cycle
                if (found && rst_ni) begin
                    req_ready_o = NUM_REQ'(1) << winner;
                    byte_next   = req_byte[winner];
                    cnt_next    = '0;
                    state_next  = SETUP;
                    if (LOCK_EN) begin
                        if (req_byte[winner] == NEWLINE) begin
                            lock_valid_next = 1'b0;
                            rr_ptr_next     = idx_add(winner, 32'd1);
                        end else begin
                            lock_valid_next = 1'b1;
                            lock_owner_next = winner;
                        end
                    end else begin
                        rr_ptr_next = idx_add(winner, 32'd1);
                    end
                end else if (LOCK_EN && lock_valid_reg && !req_valid_i[lock_owner_reg]) begin
                    if (cnt_reg == CNT_LAST) begin
                        lock_valid_next = 1'b0;
                        rr_ptr_next     = idx_add(lock_owner_reg, 32'd1);
                        cnt_next        = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (pready_i) begin
                    state_next = IDLE;
                    if (pslverr_i) begin
                        err_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= IDLE;
            byte_reg       <= '0;
            lock_valid_reg <= 1'b0;
            lock_owner_reg <= '0;
            rr_ptr_reg     <= '0;
            cnt_reg        <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            byte_reg       <= byte_next;
            lock_valid_reg <= lock_valid_next;
            lock_owner_reg <= lock_owner_next;
            rr_ptr_reg     <= rr_ptr_next;
            cnt_reg        <= cnt_next;
            err_reg        <= err_next;
        end
    end

    assign psel_o       = (state_reg != IDLE);
    assign penable_o    = (state_reg == ACCESS);
    assign pwrite_o     = psel_o;
    assign paddr_o      = psel_o ? UART_ADDR : '0;
    assign pwdata_o     = APB_DATA_WIDTH'(byte_reg);
    assign busy_o       = psel_o;
    assign lock_valid_o = lock_valid_reg;
    assign lock_owner_o = lock_owner_reg;
    assign err_o        = err_reg;

endmodule

// File: tb/tb_uart_log_arbiter.sv
// Bench for uart_log_arbiter: two instances (lock timeout 4 and locking disabled) checked every
// cycle against a transaction-level model, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_uart_log_arbiter;

    localparam int          N  = 4;
    localparam logic [31:0] UA = 32'h1000_0000;
    localparam int          LOGSZ = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              pready, pslverr;
    logic [31:0]       prdata;
    logic              rnd = 1'b0;
    assign prdata = 32'hDEAD_BEEF;

    logic [1:0][N-1:0]   valid;
    logic [1:0][N*8-1:0] data;
    logic [1:0][N-1:0]   ready;
    logic [1:0]          psel, penable, pwrite, busy, lockv, err;
    logic [1:0][31:0]    paddr, pwdata;
    logic [1:0][1:0]     owner;

    uart_log_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(4)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid[0]), .req_data_i(data[0]),
        .req_ready_o(ready[0]), .psel_o(psel[0]), .penable_o(penable[0]), .pwrite_o(pwrite[0]),
        .paddr_o(paddr[0]), .pwdata_o(pwdata[0]), .prdata_i(prdata), .pready_i(pready),
        .pslverr_i(pslverr), .busy_o(busy[0]), .lock_valid_o(lockv[0]),
        .lock_owner_o(owner[0]), .err_o(err[0]));

    uart_log_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(0)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid[1]), .req_data_i(data[1]),
        .req_ready_o(ready[1]), .psel_o(psel[1]), .penable_o(penable[1]), .pwrite_o(pwrite[1]),
        .paddr_o(paddr[1]), .pwdata_o(pwdata[1]), .prdata_i(prdata), .pready_i(pready),
        .pslverr_i(pslverr), .busy_o(busy[1]), .lock_valid_o(lockv[1]),
        .lock_owner_o(owner[1]), .err_o(err[1]));

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-requester byte queues (ring buffers); main process appends, driver consumes
    logic [7:0]        qbuf [2][N][64];
    int                qhead [2][N] = '{default: 0};
    int                qtail [2][N] = '{default: 0};
    logic [1:0][N-1:0] acc = '0;

    task automatic push(input int d, input int i, input logic [7:0] b);
        qbuf[d][i][qtail[d][i] % 64] = b;
        qtail[d][i] = qtail[d][i] + 1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                if (acc[d][i]) qhead[d][i] = qhead[d][i] + 1;
                valid[d][i] = (qtail[d][i] != qhead[d][i]) && (!rnd || $urandom_range(0, 6) != 0);
                data[d][8*i +: 8] = qbuf[d][i][qhead[d][i] % 64];
            end
        end
    end

    // Observed grants (from the DUT) for the literal checks of the directed scenarios
    int         lg_n [2] = '{0, 0};
    int         lg_cyc [2][LOGSZ];
    int         lg_idx [2][LOGSZ];
    logic [7:0] lg_byte [2][LOGSZ];
    logic       lg_err [2][LOGSZ];
    int         ns [2] = '{0, 0};
    logic [7:0] setup_byte [2][LOGSZ];

    // Model state: one in-flight transfer per DUT plus the lock/round-robin bookkeeping
    bit         m_busy [2], m_acc [2], m_lock [2], m_err [2];
    logic [7:0] m_byte [2];
    int         m_owner [2], m_rr [2], m_cnt [2];

    always @(negedge clk) begin
        int w, lt, gidx;
        logic [N-1:0] exp_ready;
        for (int d = 0; d < 2; d++) begin
            lt = (d == 0) ? 4 : 0;
            if (!rst_n) begin
                chk($sformatf("d%0d reset ready", d), 32'(ready[d]), 0);
                chk($sformatf("d%0d reset psel", d), 32'(psel[d]), 0);
                chk($sformatf("d%0d reset penable", d), 32'(penable[d]), 0);
                chk($sformatf("d%0d reset pwrite", d), 32'(pwrite[d]), 0);
                chk($sformatf("d%0d reset paddr", d), paddr[d], 0);
                chk($sformatf("d%0d reset pwdata", d), pwdata[d], 0);
                chk($sformatf("d%0d reset busy", d), 32'(busy[d]), 0);
                chk($sformatf("d%0d reset lockv", d), 32'(lockv[d]), 0);
                chk($sformatf("d%0d reset owner", d), 32'(owner[d]), 0);
                chk($sformatf("d%0d reset err", d), 32'(err[d]), 0);
                m_busy[d] = 0; m_acc[d] = 0; m_lock[d] = 0; m_err[d] = 0;
                m_byte[d] = 8'h00; m_owner[d] = 0; m_rr[d] = 0; m_cnt[d] = 0;
                acc[d] = '0;
            end else begin
                chk($sformatf("d%0d psel", d), 32'(psel[d]), 32'(m_busy[d]));
                chk($sformatf("d%0d penable", d), 32'(penable[d]), 32'(m_busy[d] && m_acc[d]));
                chk($sformatf("d%0d pwrite", d), 32'(pwrite[d]), 32'(m_busy[d]));
                chk($sformatf("d%0d paddr", d), paddr[d], m_busy[d] ? UA : 32'h0);
                if (m_busy[d]) chk($sformatf("d%0d pwdata", d), pwdata[d], {24'h0, m_byte[d]});
                chk($sformatf("d%0d busy", d), 32'(busy[d]), 32'(m_busy[d]));
                chk($sformatf("d%0d lockv", d), 32'(lockv[d]), 32'(m_lock[d]));
                if (m_lock[d]) chk($sformatf("d%0d owner", d), 32'(owner[d]), 32'(m_owner[d]));
                chk($sformatf("d%0d err", d), 32'(err[d]), 32'(m_err[d]));

                w = -1;
                if (!m_busy[d]) begin
                    if (lt > 0 && m_lock[d]) begin
                        if (valid[d][m_owner[d]]) w = m_owner[d];
                    end else begin
                        for (int k = 0; k < N; k++)
                            if (w < 0 && valid[d][(m_rr[d] + k) % N]) w = (m_rr[d] + k) % N;
                    end
                end
                exp_ready = (w >= 0) ? (N'(1) << w) : '0;
                chk($sformatf("d%0d ready", d), 32'(ready[d]), 32'(exp_ready));
                acc[d] = ready[d];

                if (ready[d] != '0 && lg_n[d] < LOGSZ) begin
                    gidx = -1;
                    for (int k = 0; k < N; k++) if (ready[d][k]) gidx = k;
                    lg_cyc[d][lg_n[d]]  = cyc;
                    lg_idx[d][lg_n[d]]  = gidx;
                    lg_byte[d][lg_n[d]] = data[d][8*gidx +: 8];
                    lg_err[d][lg_n[d]]  = err[d];
                    lg_n[d] = lg_n[d] + 1;
                end
                if (psel[d] && !penable[d] && ns[d] < LOGSZ) begin
                    setup_byte[d][ns[d]] = pwdata[d][7:0];
                    ns[d] = ns[d] + 1;
                end

                if (!m_busy[d]) begin
                    if (w >= 0) begin
                        m_busy[d] = 1; m_acc[d] = 0; m_cnt[d] = 0;
                        m_byte[d] = data[d][8*w +: 8];
                        if (lt == 0) m_rr[d] = (w + 1) % N;
                        else if (m_byte[d] == 8'h0A) begin m_lock[d] = 0; m_rr[d] = (w + 1) % N; end
                        else begin m_lock[d] = 1; m_owner[d] = w; end
                    end else if (lt > 0 && m_lock[d] && !valid[d][m_owner[d]]) begin
                        m_cnt[d] = m_cnt[d] + 1;
                        if (m_cnt[d] == lt) begin
                            m_lock[d] = 0; m_rr[d] = (m_owner[d] + 1) % N; m_cnt[d] = 0;
                        end
                    end
                end else if (!m_acc[d]) begin
                    m_acc[d] = 1;
                end else if (pready) begin
                    m_busy[d] = 0; m_acc[d] = 0;
                    if (pslverr) m_err[d] = 1;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic chk_grant(input string nm, input int d, input int k, input int idx, input logic [7:0] b);
        chk({nm, " idx"}, 32'(lg_idx[d][k]), 32'(idx));
        chk({nm, " byte"}, 32'(lg_byte[d][k]), 32'(b));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, bs, acnt, nx;
        logic [7:0] hi [3];
        logic [7:0] lb [5];
        int         li [5];
        logic       le [5];
        rst_n = 1'b0; pready = 1'b1; pslverr = 1'b0;
        tick(3);
        rst_n = 1'b1;

        // "Hi\n" from req0 on the locking instance
        do_reset();
        hi = '{8'h48, 8'h69, 8'h0A};
        b0 = lg_n[0]; bs = ns[0];
        for (int k = 0; k < 3; k++) push(0, 0, hi[k]);
        tick(15);
        for (int k = 0; k < 3; k++) begin
            chk_grant("hi", 0, b0 + k, 0, hi[k]);
            chk("hi setup pwdata", 32'(setup_byte[0][bs + k]), 32'(hi[k]));
        end
        chk("hi spacing 1", 32'(lg_cyc[0][b0+1] - lg_cyc[0][b0]), 3);
        chk("hi spacing 2", 32'(lg_cyc[0][b0+2] - lg_cyc[0][b0+1]), 3);
        chk("hi lock after newline", 32'(lockv[0]), 0);
        b0 = lg_n[0];
        push(0, 0, 8'h70); push(0, 1, 8'h71);
        tick(20);
        chk("rr after newline first", 32'(lg_idx[0][b0]), 1);
        chk("rr after newline second", 32'(lg_idx[0][b0+1]), 0);

        // Line lock: "AB\n" from req0 against "C\n" from req1
        do_reset();
        b0 = lg_n[0];
        push(0, 0, 8'h41); push(0, 0, 8'h42); push(0, 0, 8'h0A);
        push(0, 1, 8'h43); push(0, 1, 8'h0A);
        tick(25);
        li = '{0, 0, 0, 1, 1};
        lb = '{8'h41, 8'h42, 8'h0A, 8'h43, 8'h0A};
        for (int k = 0; k < 5; k++) chk_grant("lock order", 0, b0 + k, li[k], lb[k]);

        // Lock timeout: owner goes quiet after one byte, req1 waits
        do_reset();
        b0 = lg_n[0];
        push(0, 0, 8'h41); push(0, 1, 8'h5A);
        tick(20);
        chk_grant("timeout first", 0, b0, 0, 8'h41);
        chk_grant("timeout second", 0, b0 + 1, 1, 8'h5A);
        chk("timeout gap", 32'(lg_cyc[0][b0+1] - lg_cyc[0][b0]), 7);

        // APB wait states: five ACCESS cycles with pready low
        do_reset();
        pready = 1'b0;
        b0 = lg_n[0]; acnt = 0;
        push(0, 0, 8'h0A); push(0, 1, 8'h56);
        for (int k = 0; k < 40 && acnt < 6; k++) begin
            tick();
            if (penable[0]) acnt++;
            if (acnt == 6) pready = 1'b1;
        end
        chk("wait access cycles", 32'(acnt), 6);
        pready = 1'b1;
        tick(10);
        chk_grant("wait first", 0, b0, 0, 8'h0A);
        chk_grant("wait second", 0, b0 + 1, 1, 8'h56);
        chk("wait gap", 32'(lg_cyc[0][b0+1] - lg_cyc[0][b0]), 8);

        // No-lock fairness with a slave error on the 2nd transfer
        do_reset();
        b0 = lg_n[1];
        for (int i = 0; i < N; i++) begin
            push(1, i, 8'(8'h61 + i)); push(1, i, 8'(8'h65 + i));
        end
        for (int k = 0; k < 60 && (lg_n[1] - b0) < 5; k++) begin
            tick();
            pslverr = ((lg_n[1] - b0) == 2);
        end
        pslverr = 1'b0;
        li = '{0, 1, 2, 3, 0};
        le = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 5; k++) begin
            chk("fair grant", 32'(lg_idx[1][b0+k]), 32'(li[k]));
            chk("err at grant", 32'(lg_err[1][b0+k]), 32'(le[k]));
        end
        tick(30);
        chk("err sticky", 32'(err[1]), 1);

        // Reset asserted during ACCESS
        do_reset();
        pready = 1'b0;
        b0 = lg_n[0];
        push(0, 2, 8'h58);
        for (int k = 0; k < 20 && !penable[0]; k++) tick();
        chk("reset test reached access", 32'(penable[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("async reset psel", 32'(psel[0]), 0);
        chk("async reset penable", 32'(penable[0]), 0);
        chk("async reset paddr", paddr[0], 0);
        tick(2);
        rst_n = 1'b1;
        pready = 1'b1;
        tick(10);
        nx = 0;
        for (int k = b0; k < lg_n[0]; k++) if (lg_byte[0][k] == 8'h58) nx++;
        chk("byte not resent after reset", 32'(nx), 1);
        chk("idle after reset", 32'(psel[0]), 0);

        // Randomised traffic on both instances
        rnd = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < N; i++)
                    if ((qtail[d][i] - qhead[d][i]) < 3 && $urandom_range(0, 3) == 0)
                        push(d, i, ($urandom_range(0, 4) == 0) ? 8'h0A : 8'($urandom_range(32, 126)));
            pready  = ($urandom_range(0, 3) != 0);
            pslverr = ($urandom_range(0, 9) == 0);
            rst_n   = ($urandom_range(0, 599) != 0);
        end
        rnd = 1'b0; rst_n = 1'b1; pready = 1'b1; pslverr = 1'b0;
        tick(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
